d_serial_bch_encoder_ctrl: RTL
==============================

# d_serial_bch_encoder_ctrl

Sequential wrapper around the serial BCH next-parity function. It accepts a serial message stream one bit per handshake and passes each bit straight through to a serial codeword output. It accumulates the 168-bit parity in a register and, once the frame's message bits are exhausted, appends the parity bits MSB first. It sits between the page-buffer serializer and the NAND write-data packer in the BCH encode path.

## Interface
- `P_MSG_BITS`, default 8192: message bits per frame; legal range 1..16215.
- `P_CNT_W`, default 14: width of the message counter; must satisfy `2^P_CNT_W > P_MSG_BITS`.
- Parity length is `` `D_BCH_ENC_PRT_LENGTH `` (168), taken from the shared header; it is not a parameter.

Ports:
- `i_clk`  in  1  clock.
- `i_RESET`  in  1  reset; synchronous, active-high.
- `i_start`  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- `i_message_valid`  in  1  `i_message` is valid.
- `i_message`  in  1  message bit.
- `o_message_ready`  out  1  message bit is accepted when valid && ready.
- `o_code_valid`  out  1  `o_code_bit` is valid.
- `o_code_bit`  out  1  codeword bit (message bits, then parity bits).
- `o_code_last`  out  1  marks the final parity bit of the frame.
- `i_code_ready`  in  1  downstream accepts the code bit when valid && ready.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, MSG, PAR, DRAIN.
- **IDLE**
  - On `i_start`: parity register ← 0, message counter ← 0, go to MSG.
- **MSG**
  - `o_message_ready = !o_code_valid || i_code_ready`.
  - On an input handshake:
    - parity ← next_parity(`i_message`, parity);
    - output register ← `i_message`, with `o_code_valid` set;
    - counter += 1.
  - When the handshake that makes counter == `P_MSG_BITS` occurs: parity counter ← 0, go to PAR.
- **PAR**
  - `o_message_ready = 0`.
  - Whenever the output register is empty or being consumed:
    - output register ← parity[167];
    - parity ← parity << 1 (zero fill);
    - parity counter += 1.
  - When the parity bit with index 167 is loaded: set `o_code_last` with it and go to DRAIN.
- **DRAIN**
  - Wait for the handshake on the last bit, then clear `o_code_valid`/`o_code_last` and go to IDLE.
- `i_start` outside IDLE is ignored.
- `i_message_valid` in IDLE, PAR or DRAIN is ignored; ready is 0 there.
- Output register behaviour:
  - Holds its value and `o_code_last` while valid && !ready.
  - Clears valid after a consume with no new load.

## Timing
- Reset values: `o_message_ready` 0, `o_code_valid` 0, `o_code_bit` 0, `o_code_last` 0, `o_busy` 0; parity register 0; state IDLE.
- Reset asserted mid-frame aborts the frame: every output is at its reset value on the next cycle and no partial parity is emitted.
- Latency: input handshake in cycle N → the bit appears on `o_code_bit` in cycle N+1.
- Parity update: the parity register reflects the new bit in cycle N+1.
- The first parity bit loads on the cycle after the final message handshake, provided the output register is free.
- Throughput with `i_code_ready` held high: 1 bit per cycle, no bubble at the MSG→PAR boundary.
- Frame length: `P_MSG_BITS` + 168 output bits.
- IDLE to first ready: `i_start` in cycle N → `o_message_ready` can be 1 in cycle N+1.
- Next frame: `i_start` is accepted in the cycle after DRAIN returns to IDLE.
- Simultaneous consume and load in the same cycle is a legal pass-through with no stall.
- The counters never wrap: the terminal counts force the state transition.

## Structure
- Shared package/header holds:
  - `` `D_BCH_ENC_PRT_LENGTH ``;
  - the state encoding constants (IDLE=0, MSG=1, PAR=2, DRAIN=3).
- One sub-module: `d_serial_m_lfs_XOR` provides the combinational next_parity.
  - It is instantiated once, with `i_cur_parity` = parity register.
  - Its output is registered here; the sub-module is not modified.
- Parity counter: 8 bits.
- Message counter: `P_CNT_W` bits.

## Test plan
- **All-zero message:** `P_MSG_BITS`=8, zeros streamed, `i_code_ready`=1.
  - 176 output bits, all 0.
  - `o_code_last` only on bit 176.
  - `o_busy` falls one cycle after the last handshake.
- **Single one:** `P_MSG_BITS`=1, message bit 1.
  - Output bit 0 = 1.
  - Parity bits 1..168 equal generator coefficients G[167] down to G[0] (G[0]=1).
  - `o_code_last` on the 169th bit.
- **Backpressure:** `P_MSG_BITS`=16, random message, `i_code_ready` low for 5 cycles at message bit 7 and again at parity bit 40.
  - `o_message_ready` is 0 during the stall.
  - `o_code_bit`/`o_code_last` are held.
  - The output stream is bit-identical to an unstalled golden-model run.
- **Mid-frame reset:** `i_RESET` after 100 of 8192 message bits.
  - Next cycle: all outputs 0.
  - A new `i_start` frame of all zeros yields all-zero parity.
- **Spurious start:** `i_start` pulsed during MSG and during PAR is ignored; the frame completes with correct length and parity.
- **Random frames:** 20 back-to-back random frames, `P_MSG_BITS`=8192, random ready duty of 70%.
  - Each frame's parity matches the software BCH(t=12, GF(2^14)) encoder.
  - Every codeword has a zero syndrome.

Source files
------------

// File: rtl/d_serial_bch_encoder_ctrl_pkg.sv
// Shared definitions for the serial BCH(t=12, GF(2^14)) encoder.
//   - D_BCH_ENC_PRT_LENGTH : parity length in bits (168)
//   - bch_state_e          : controller state encoding (IDLE=0, MSG=1, PAR=2, DRAIN=3)
//   - BchGen               : generator polynomial g(x) without its x^168 term,
//                            bit i = coefficient of x^i
// The field is GF(2^14) built on x^14 + x^5 + x^3 + x + 1 with alpha = x.
// g(x) is the product of the minimal polynomials of alpha^1, alpha^3, ... alpha^23
// and is evaluated once at elaboration.

`ifndef D_BCH_ENC_PRT_LENGTH
`define D_BCH_ENC_PRT_LENGTH 168
`endif

package d_serial_bch_encoder_ctrl_pkg;

    localparam int unsigned PrtLength = `D_BCH_ENC_PRT_LENGTH;
    localparam int unsigned GfM       = 14;
    localparam int unsigned BchT      = 12;

    // Reduction mask for x^14 = x^5 + x^3 + x + 1.
    localparam logic [GfM-1:0] GfReduce = 14'h002b;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMsg   = 2'd1,
        StPar   = 2'd2,
        StDrain = 2'd3
    } bch_state_e;

    function automatic logic [GfM-1:0] gf_mul(input logic [GfM-1:0] a, input logic [GfM-1:0] b);
        logic [GfM-1:0] acc;
        logic [GfM-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < GfM; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[GfM-1] ? ((x << 1) ^ GfReduce) : (x << 1);
        end
        return acc;
    endfunction

    // Every odd root below 2t lies in a distinct 14-element cyclotomic coset, so each
    // minimal polynomial is the product of (x + beta^(2^j)) for j = 0..13.
    function automatic logic [PrtLength:0] bch_gen_poly();
        logic [PrtLength:0]      g;
        logic [PrtLength:0]      prod;
        logic [GfM:0][GfM-1:0]   c;
        logic [GfM:0]            m;
        logic [GfM-1:0]          beta;
        g = '0;
        g[0] = 1'b1;
        for (int t = 0; t < BchT; t++) begin
            beta = 14'd1;
            for (int k = 0; k < 2 * t + 1; k++) beta = gf_mul(beta, 14'd2);
            c = '0;
            c[0] = 14'd1;
            for (int j = 0; j < GfM; j++) begin
                for (int k = GfM; k > 0; k--) c[k] = c[k-1] ^ gf_mul(c[k], beta);
                c[0] = gf_mul(c[0], beta);
                beta = gf_mul(beta, beta);
            end
            // Coefficients of a minimal polynomial are all in GF(2).
            for (int k = 0; k <= GfM; k++) m[k] = c[k][0];
            prod = '0;
            for (int k = 0; k <= GfM; k++) begin
                if (m[k]) prod = prod ^ (g << k);
            end
            g = prod;
        end
        return g;
    endfunction

    localparam logic [PrtLength:0]   BchGenFull = bch_gen_poly();
    localparam logic [PrtLength-1:0] BchGen     = BchGenFull[PrtLength-1:0];

endpackage

// File: rtl/d_serial_m_lfs_XOR.sv
// Combinational next-parity step of the serial systematic BCH encoder (one LFSR shift).
//   i_message     : incoming message bit
//   i_cur_parity  : current parity register, bit 167 = coefficient of x^167
//   o_next_parity : parity after absorbing i_message

module d_serial_m_lfs_XOR
    import d_serial_bch_encoder_ctrl_pkg::*;
(
    input  logic                 i_message,
    input  logic [PrtLength-1:0] i_cur_parity,
    output logic [PrtLength-1:0] o_next_parity
);

    logic feedback;

    always_comb begin
        feedback      = i_message ^ i_cur_parity[PrtLength-1];
        o_next_parity = {i_cur_parity[PrtLength-2:0], 1'b0} ^ ({PrtLength{feedback}} & BchGen);
    end

endmodule

// File: rtl/d_serial_bch_encoder_ctrl.sv
// Serial BCH encoder controller. Message bits pass straight through to the codeword
// output while the parity accumulates; the 168 parity bits follow, MSB first.
//   i_clk, i_RESET (sync, active-high)
//   i_start                            : begin a frame (IDLE only)
//   i_message_valid / i_message        : serial message input
//   o_message_ready                    : message handshake ready
//   o_code_valid / o_code_bit          : serial codeword output
//   o_code_last                        : final parity bit of the frame
//   i_code_ready                       : downstream ready
//   o_busy                             : not IDLE

module d_serial_bch_encoder_ctrl
    import d_serial_bch_encoder_ctrl_pkg::*;
#(
    parameter int unsigned P_MSG_BITS = 8192,
    parameter int unsigned P_CNT_W    = 14
) (
    input  logic i_clk,
    input  logic i_RESET,
    input  logic i_start,
    input  logic i_message_valid,
    input  logic i_message,
    output logic o_message_ready,
    output logic o_code_valid,
    output logic o_code_bit,
    output logic o_code_last,
    input  logic i_code_ready,
    output logic o_busy
);

    localparam logic [P_CNT_W-1:0] MsgLast = P_CNT_W'(P_MSG_BITS - 1);
    localparam logic [7:0]         ParLast = 8'(PrtLength - 1);

    bch_state_e           state_q, state_d;
    logic [PrtLength-1:0] parity_q, parity_d;
    logic [PrtLength-1:0] parity_next;
    logic [P_CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
    logic [7:0]           par_cnt_q, par_cnt_d;
    logic                 code_valid_q, code_valid_d;
    logic                 code_bit_q, code_bit_d;
    logic                 code_last_q, code_last_d;
    logic                 out_free;
    logic                 msg_ready;

    d_serial_m_lfs_XOR u_lfs_xor (
        .i_message     (i_message),
        .i_cur_parity  (parity_q),
        .o_next_parity (parity_next)
    );

    // Output register can take a new bit when empty or being consumed this cycle.
    assign out_free = !code_valid_q || i_code_ready;

    always_comb begin
        state_d      = state_q;
        parity_d     = parity_q;
        msg_cnt_d    = msg_cnt_q;
        par_cnt_d    = par_cnt_q;
        code_valid_d = code_valid_q;
        code_bit_d   = code_bit_q;
        code_last_d  = code_last_q;
        msg_ready    = 1'b0;

        if (code_valid_q && i_code_ready) begin
            code_valid_d = 1'b0;
            code_last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    parity_d  = '0;
                    msg_cnt_d = '0;
                    state_d   = StMsg;
                end
            end
            StMsg: begin
                msg_ready = out_free;
                if (i_message_valid && out_free) begin
                    parity_d     = parity_next;
                    code_bit_d   = i_message;
                    code_valid_d = 1'b1;
                    code_last_d  = 1'b0;
                    msg_cnt_d    = msg_cnt_q + 1'b1;
                    if (msg_cnt_q == MsgLast) begin
                        par_cnt_d = '0;
                        state_d   = StPar;
                    end
                end
            end
            StPar: begin
                if (out_free) begin
                    code_bit_d   = parity_q[PrtLength-1];
                    code_valid_d = 1'b1;
                    parity_d     = parity_q << 1;
                    par_cnt_d    = par_cnt_q + 8'd1;
                    if (par_cnt_q == ParLast) begin
                        code_last_d = 1'b1;
                        state_d     = StDrain;
                    end
                end
            end
            StDrain: begin
                if (code_valid_q && i_code_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            state_q      <= StIdle;
            parity_q     <= '0;
            msg_cnt_q    <= '0;
            par_cnt_q    <= '0;
            code_valid_q <= 1'b0;
            code_bit_q   <= 1'b0;
            code_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            parity_q     <= parity_d;
            msg_cnt_q    <= msg_cnt_d;
            par_cnt_q    <= par_cnt_d;
            code_valid_q <= code_valid_d;
            code_bit_q   <= code_bit_d;
            code_last_q  <= code_last_d;
        end
    end

    assign o_message_ready = msg_ready;
    assign o_code_valid    = code_valid_q;
    assign o_code_bit      = code_bit_q;
    assign o_code_last     = code_last_q;
    assign o_busy          = (state_q != StIdle);

endmodule
